bshifter_4bit: RTL and testbench

BSHIFTER_4BIT -- requirements
Module: bshifter_4bit

---
 rtl/bshifter_4bit.sv | 64 ++++++
 tb/tb_bshifter_4bit.sv | 110 +++++++++++
 2 files changed

// File: rtl/bshifter_4bit.sv
// 4-bit registered barrel rotator: rotates {w3,w2,w1,w0} right by {s1,s0}.
// Each output bit comes from its own mux4_1 and is captured in a 4-bit register.

module mux4_1 (
   input  logic       w0,
   input  logic       w1,
   input  logic       w2,
   input  logic       w3,
   input  logic [1:0] s,
   output logic       f
);

   always_comb begin
      f = w0;
      case (s)
         2'd0:    f = w0;
         2'd1:    f = w1;
         2'd2:    f = w2;
         2'd3:    f = w3;
         default: f = w0;
      endcase
   end

endmodule

module bshifter_4bit (
   output logic y3,
   output logic y2,
   output logic y1,
   output logic y0,
   input  logic s1,
   input  logic s0,
   input  logic w3,
   input  logic w2,
   input  logic w1,
   input  logic w0,
   input  logic clk,
   input  logic rst
);

   logic [1:0] sel_p0;
   logic [3:0] rot_p0;
   logic [3:0] y_p1;

   assign sel_p0 = {s1, s0};

   // Stage p0: mux data inputs are ordered by rotate amount 0..3.
   mux4_1 u_mux3 (.w0(w3), .w1(w0), .w2(w1), .w3(w2), .s(sel_p0), .f(rot_p0[3]));
   mux4_1 u_mux2 (.w0(w2), .w1(w3), .w2(w0), .w3(w1), .s(sel_p0), .f(rot_p0[2]));
   mux4_1 u_mux1 (.w0(w1), .w1(w2), .w2(w3), .w3(w0), .s(sel_p0), .f(rot_p0[1]));
   mux4_1 u_mux0 (.w0(w0), .w1(w1), .w2(w2), .w3(w3), .s(sel_p0), .f(rot_p0[0]));

   // Stage p1: output register; reset clears the result and wins over the load.
   always_ff @(posedge clk) begin
      if (rst) begin
         y_p1 <= 4'b0000;
      end else begin
         y_p1 <= rot_p0;
      end
   end

   assign {y3, y2, y1, y0} = y_p1;

endmodule

// File: tb/tb_bshifter_4bit.sv
// Self-checking bench for bshifter_4bit: directed steps, exhaustive sweep and
// random vectors compared against an arithmetic rotate-right model.

module tb_bshifter_4bit;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic s1 = 1'b0, s0 = 1'b0;
   logic w3 = 1'b0, w2 = 1'b0, w1 = 1'b0, w0 = 1'b0;
   logic y3, y2, y1, y0;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   bshifter_4bit dut (
      .y3(y3), .y2(y2), .y1(y1), .y0(y0),
      .s1(s1), .s0(s0),
      .w3(w3), .w2(w2), .w1(w1), .w0(w0),
      .clk(clk), .rst(rst)
   );

   // Rotate right by k: double the word, shift, keep the low nibble.
   function automatic logic [3:0] rotr(input logic [3:0] w, input logic [1:0] k);
      logic [7:0] d;
      d = {w, w} >> k;
      return d[3:0];
   endfunction

   task automatic apply(input logic r, input logic [1:0] s, input logic [3:0] w);
      rst = r;
      {s1, s0} = s;
      {w3, w2, w1, w0} = w;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [3:0] exp);
      logic [3:0] obs;
      obs = {y3, y2, y1, y0};
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   initial begin
      logic [3:0] w;
      logic [1:0] s;
      logic       r;
      logic [3:0] exp_y;

      // Reset for two edges with non-zero inputs present
      apply(1'b1, 2'b11, 4'b1101);
      tick(); check("reset_edge1", 4'b0000);
      tick(); check("reset_edge2", 4'b0000);

      // Single rotations of 1101
      apply(1'b0, 2'b00, 4'b1101); tick(); check("k0_1101", 4'b1101);
      apply(1'b0, 2'b01, 4'b1101); tick(); check("k1_1101", 4'b1110);
      apply(1'b0, 2'b10, 4'b1101); tick(); check("k2_1101", 4'b0111);
      apply(1'b0, 2'b11, 4'b1101); tick(); check("k3_1101", 4'b1011);

      // Back-to-back: output holds old value until the edge, then updates
      apply(1'b0, 2'b00, 4'b1101); check("b2b_hold0", 4'b1011); tick(); check("b2b_k0", 4'b1101);
      apply(1'b0, 2'b01, 4'b1101); check("b2b_hold1", 4'b1101); tick(); check("b2b_k1", 4'b1110);
      apply(1'b0, 2'b10, 4'b1101); check("b2b_hold2", 4'b1110); tick(); check("b2b_k2", 4'b0111);
      apply(1'b0, 2'b11, 4'b1101); check("b2b_hold3", 4'b0111); tick(); check("b2b_k3", 4'b1011);

      // Mid-cycle data change must not reach the output before the edge
      apply(1'b0, 2'b01, 4'b1101); tick(); check("mid_pre", 4'b1110);
      #2; apply(1'b0, 2'b01, 4'b0001);
      #1; check("mid_hold", 4'b1110);
      tick(); check("mid_after", 4'b1000);

      // Exhaustive sweep with reset asserted at one point mid-way
      for (int i = 0; i < 64; i++) begin
         s = i[5:4];
         w = i[3:0];
         r = (i == 32);
         apply(r, s, w);
         tick();
         exp_y = r ? 4'b0000 : rotr(w, s);
         check(r ? "sweep_rst" : "sweep", exp_y);
      end

      // First edge after the mid-sweep reset loads fresh data, no stale value
      apply(1'b0, 2'b10, 4'b0110); tick(); check("post_rst_load", rotr(4'b0110, 2'b10));

      // Random vectors with occasional reset
      for (int i = 0; i < 200; i++) begin
         s = 2'($urandom_range(0, 3));
         w = 4'($urandom_range(0, 15));
         r = ($urandom_range(0, 15) == 0);
         apply(r, s, w);
         tick();
         exp_y = r ? 4'b0000 : rotr(w, s);
         check("random", exp_y);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
